// File: rtl/ddr_frame_fetch.sv
// ddr_frame_fetch: AXI4 read master that streams one frame per vsync fall into a
// first-word-fall-through pixel FIFO. Defining FRAME_FETCH_DBLBUF_EN alternates two frame bases.
module ddr_frame_fetch #(
  parameter logic [31:0] FRAME0_ADDR = 32'h1000_0000,
  parameter int          FRAME_BYTES = 153600,
  parameter int          BURST_LEN   = 16,
  parameter int          FIFO_WORDS  = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vsync,
  input  logic        pixel_rd,
  output logic [15:0] pixel_data,
  output logic        underflow,
  output logic [31:0] m_araddr,
  output logic [7:0]  m_arlen,
  output logic [2:0]  m_arsize,
  output logic [1:0]  m_arburst,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic [63:0] m_rdata,
  input  logic [1:0]  m_rresp,
  input  logic        m_rlast,
  input  logic        m_rvalid,
  output logic        m_rready
);
  localparam int              AW          = $clog2(FIFO_WORDS);
  localparam int              NBURST      = FRAME_BYTES / (BURST_LEN * 8);
  localparam int              CW          = $clog2(NBURST + 1);
  localparam logic [31:0]     BURST_BYTES = 32'(BURST_LEN * 8);
  localparam logic [AW:0]     FREE_MIN    = (AW + 1)'(BURST_LEN);
  localparam logic [AW:0]     DEPTH       = (AW + 1)'(FIFO_WORDS);
  localparam logic [CW-1:0]   LAST_BURST  = CW'(NBURST - 1);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_DATA, S_FLUSH, S_DONE} state_t;

  state_t        r_state;
  logic          r_vs, r_fs;
  logic          r_arvalid, r_rready, r_flush_pend, r_underflow;
  logic [31:0]   r_araddr, r_base;
  logic [CW-1:0] r_burst_cnt;
  logic [AW:0]   r_wptr, r_rptr;
  logic [1:0]    r_lane;
  logic [63:0]   r_mem [FIFO_WORDS];

  logic [31:0]   w_new_base;
  logic [AW:0]   w_count, w_free;
  logic [63:0]   w_head;
  logic          w_empty, w_r_hs, w_wr, w_pop;
  logic          w_unused_rresp;

  assign w_unused_rresp = ^m_rresp;

`ifdef FRAME_FETCH_DBLBUF_EN
  logic r_sel;
  assign w_new_base = r_sel ? (FRAME0_ADDR + 32'(FRAME_BYTES)) : FRAME0_ADDR;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       r_sel <= 1'b0;
    else if (r_fs) r_sel <= ~r_sel;
  end
`else
  assign w_new_base = FRAME0_ADDR;
`endif

  assign m_arlen    = 8'(BURST_LEN - 1);
  assign m_arsize   = 3'b011;
  assign m_arburst  = 2'b01;
  assign m_arvalid  = r_arvalid;
  assign m_araddr   = r_araddr;
  assign m_rready   = r_rready;
  assign underflow  = r_underflow;

  assign w_count    = r_wptr - r_rptr;
  assign w_free     = DEPTH - w_count;
  assign w_empty    = (r_wptr == r_rptr);
  assign w_head     = r_mem[r_rptr[AW-1:0]];
  assign w_r_hs     = m_rvalid & r_rready;
  assign w_wr       = w_r_hs & (r_state == S_DATA) & ~r_fs;
  assign w_pop      = pixel_rd & ~w_empty & ~r_fs;
  assign pixel_data = w_empty ? 16'h0000 : w_head[{r_lane, 4'b0000} +: 16];

  // frame_start is the cycle after vsync is first sampled low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vs <= 1'b0;
      r_fs <= 1'b0;
    end else begin
      r_vs <= vsync;
      r_fs <= r_vs & ~vsync;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= m_rdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_lane      <= 2'd0;
      r_underflow <= 1'b0;
    end else if (r_fs) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_lane      <= 2'd0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_pop) begin
        r_lane <= r_lane + 2'd1;
        if (r_lane == 2'd3) r_rptr <= r_rptr + 1'b1;
      end
      if (pixel_rd && w_empty) r_underflow <= 1'b1;
    end
  end

  // A pending AR keeps its address; the new base is applied once that burst is accepted and flushed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_araddr     <= FRAME0_ADDR;
      r_base       <= FRAME0_ADDR;
      r_flush_pend <= 1'b0;
      r_burst_cnt  <= '0;
    end else if (r_fs) begin
      r_base      <= w_new_base;
      r_burst_cnt <= '0;
      case (r_state)
        S_REQ: begin
          if (r_arvalid) begin
            if (m_arready) begin
              r_arvalid    <= 1'b0;
              r_rready     <= 1'b1;
              r_araddr     <= w_new_base;
              r_flush_pend <= 1'b0;
              r_state      <= S_FLUSH;
            end else begin
              r_flush_pend <= 1'b1;
            end
          end else begin
            r_araddr <= w_new_base;
          end
        end
        S_DATA, S_FLUSH: begin
          r_araddr <= w_new_base;
          // a last beat taken now ends the burst, so there is nothing left to flush
          if (w_r_hs && m_rlast) begin
            r_rready <= 1'b0;
            r_state  <= S_REQ;
          end else begin
            r_state  <= S_FLUSH;
          end
        end
        default: begin
          r_araddr <= w_new_base;
          r_state  <= S_REQ;
        end
      endcase
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
        end
        S_REQ: begin
          if (!r_arvalid) begin
            if (w_free >= FREE_MIN) r_arvalid <= 1'b1;
          end else if (m_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            if (r_flush_pend) begin
              r_flush_pend <= 1'b0;
              r_araddr     <= r_base;
              r_state      <= S_FLUSH;
            end else begin
              r_state      <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (w_r_hs && m_rlast) begin
            r_rready <= 1'b0;
            r_araddr <= r_araddr + BURST_BYTES;
            if (r_burst_cnt == LAST_BURST) begin
              r_state <= S_DONE;
            end else begin
              r_burst_cnt <= r_burst_cnt + 1'b1;
              r_state     <= S_REQ;
            end
          end
        end
        S_FLUSH: begin
          if (w_r_hs && m_rlast) begin
            r_rready <= 1'b0;
            r_state  <= S_REQ;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_frame_fetch.sv
// tb_ddr_frame_fetch: randomized AXI slave plus a pixel-stream reference model for ddr_frame_fetch.
// Honours FRAME_FETCH_DBLBUF_EN so the expected frame base follows the build.
module tb_ddr_frame_fetch;
  localparam logic [31:0] F0   = 32'h1000_0000;
  localparam int          BL   = 16;
  localparam int          FW   = 256;
  localparam int          NB   = 48;
  localparam int          FB   = NB * BL * 8;
  localparam int          NPIX = FB / 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vsync = 1'b1;
  logic        pixel_rd = 1'b0;
  logic [15:0] pixel_data;
  logic        underflow;
  logic [31:0] m_araddr;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst;
  logic        m_arvalid;
  logic        m_arready = 1'b0;
  logic [63:0] m_rdata = 64'h0;
  logic [1:0]  m_rresp = 2'b00;
  logic        m_rlast = 1'b0;
  logic        m_rvalid = 1'b0;
  logic        m_rready;

  ddr_frame_fetch #(
    .FRAME0_ADDR(F0), .FRAME_BYTES(FB), .BURST_LEN(BL), .FIFO_WORDS(FW)
  ) dut (
    .clk(clk), .rst(rst), .vsync(vsync), .pixel_rd(pixel_rd),
    .pixel_data(pixel_data), .underflow(underflow),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid),
    .m_rready(m_rready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          tag;
  } burst_t;

  int total = 0;
  int bad   = 0;

  // reference model: pixels of the current frame in address order
  int          epoch = 0, frame_no = 0;
  logic [31:0] base_m = F0;
  int          ar_idx = 0, avail = 0, pix_idx = 0, wr_words = 0, pops = 0;
  bit          ufl = 1'b0, fs_now = 1'b0, vs_prev = 1'b1;
  // AXI slave state
  burst_t      rq[$];
  int          beat = 0, ar_tag = 0;
  bit          rv_pend = 1'b0, arv_prev = 1'b0;
  logic [31:0] ar_hold = 32'h0;
  // stimulus knobs
  int          p_arr = 100, p_rv = 100, p_pop = 50, pop_budget = 0, want_arv = -1;
  bit          vs_next = 1'b1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] mem_word(input logic [31:0] a);
    logic [31:0] p;
    p = a >> 1;
    return {16'(p + 32'd3), 16'(p + 32'd2), 16'(p + 32'd1), 16'(p)};
  endfunction

  function automatic logic [15:0] exp_pix(input logic [31:0] b, input int i);
    return 16'((b >> 1) + 32'(i));
  endfunction

  task automatic cycle();
    bit          ar_hs, r_hs, rd;
    logic [31:0] ar_addr_s;
    int          occ;
    @(negedge clk);
    occ = wr_words - pops / 4;
    chk("pixel_data", pixel_data, (avail > 0) ? 64'(exp_pix(base_m, pix_idx)) : 64'h0);
    chk("underflow", underflow, ufl);
    chk("fifo_bound", occ <= FW, 1'b1);
    if (m_arvalid && !arv_prev) begin
      ar_tag  = epoch;
      ar_hold = m_araddr;
      chk("space_before_ar", occ <= FW - BL, 1'b1);
    end else if (m_arvalid) begin
      chk("araddr_stable", m_araddr, ar_hold);
    end
    if (want_arv >= 0) chk("arvalid_level", m_arvalid, want_arv[0]);

    vsync     = vs_next;
    m_arready = ($urandom_range(99) < p_arr);
    m_rresp   = 2'($urandom);
    if (!rv_pend) begin
      m_rvalid = (rq.size() > 0) && ($urandom_range(99) < p_rv);
      if (m_rvalid) begin
        m_rdata = mem_word(rq[0].addr + 32'(8 * beat));
        m_rlast = (beat == BL - 1);
      end else begin
        m_rdata = {$urandom, $urandom};
        m_rlast = 1'($urandom);
      end
      rv_pend = m_rvalid;
    end
    pixel_rd  = (pop_budget > 0) || ($urandom_range(99) < p_pop);
    ar_hs     = m_arvalid && m_arready;
    r_hs      = m_rvalid && m_rready;
    rd        = pixel_rd;
    ar_addr_s = m_araddr;
    arv_prev  = m_arvalid;
    @(posedge clk);

    if (fs_now) begin
      epoch++;
      frame_no++;
`ifdef FRAME_FETCH_DBLBUF_EN
      base_m = (frame_no % 2 == 0) ? F0 + 32'(FB) : F0;
`else
      base_m = F0;
`endif
      ar_idx = 0; avail = 0; pix_idx = 0; wr_words = 0; pops = 0; ufl = 1'b0;
    end else if (rd) begin
      if (avail > 0) begin
        pix_idx++; avail--; pops++;
        if (pop_budget > 0) pop_budget--;
      end else begin
        ufl = 1'b1;
      end
    end
    if (ar_hs) begin
      chk("single_outstanding", rq.size(), 0);
      chk("ar_after_frame_start", epoch > 0, 1'b1);
      chk("arlen", m_arlen, BL - 1);
      chk("arsize_arburst", {m_arsize, m_arburst}, 5'b011_01);
      if (ar_tag == epoch && !fs_now) begin
        chk("araddr", ar_addr_s, base_m + 32'(128 * ar_idx));
        chk("ar_within_frame", ar_idx < NB, 1'b1);
        ar_idx++;
        rq.push_back('{addr: ar_addr_s, tag: epoch});
      end else begin
        rq.push_back('{addr: ar_addr_s, tag: -1});
      end
    end
    if (r_hs) begin
      if (rq[0].tag == epoch && !fs_now) begin
        avail += 4;
        wr_words++;
      end
      rv_pend = 1'b0;
      if (beat == BL - 1) begin
        beat = 0;
        void'(rq.pop_front());
      end else begin
        beat++;
      end
    end
    fs_now  = vs_prev && !vsync;
    vs_prev = vsync;
  endtask

  task automatic start_frame();
    vs_next = 1'b0;
    cycle();
    cycle();
    vs_next = 1'b1;
    cycle();
  endtask

  task automatic wait_frame(input int bound);
    int n;
    n = 0;
    while (!(ar_idx == NB && pix_idx == NPIX) && n < bound) begin
      cycle();
      n++;
    end
    chk("frame_bursts", ar_idx, NB);
    chk("frame_pixels", pix_idx, NPIX);
  endtask

  initial begin
    int  n;
    bit  seen;
    repeat (2) @(negedge clk);
    chk("rst_arvalid", m_arvalid, 1'b0);
    chk("rst_rready", m_rready, 1'b0);
    chk("rst_araddr", m_araddr, F0);
    chk("rst_pixel", pixel_data, 16'h0);
    chk("rst_underflow", underflow, 1'b0);
    chk("rst_arlen", m_arlen, 8'd15);
    rst = 1'b0;

    // idle before any frame: popping an empty FIFO flags underflow, no AR
    p_pop = 30;
    repeat (20) cycle();

    // full frame with random backpressure on every channel
    p_arr = 60; p_rv = 80; p_pop = 65;
    start_frame();
    wait_frame(12000);
    p_pop = 50;
    repeat (40) cycle();

    // AR held off: arvalid and address must stay put
    p_arr = 0; p_pop = 0;
    start_frame();
    repeat (4) cycle();
    want_arv = 1;
    repeat (100) cycle();
    want_arv = -1;
    p_arr = 100;

    // fill the FIFO, then free exactly one burst of space word by word
    p_rv = 100;
    start_frame();
    repeat (600) cycle();
    want_arv = 0;
    repeat (20) cycle();
    pop_budget = 60;
    n = 0;
    while (pop_budget > 0 && n < 200) begin cycle(); n++; end
    repeat (20) cycle();
    want_arv = -1;
    pop_budget = 4;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 20) begin
      cycle();
      seen = arv_prev;
      n++;
    end
    chk("ar_once_space_free", seen, 1'b1);

    // restart in the middle of a burst, around beat 7
    p_pop = 40; p_rv = 90; p_arr = 80;
    start_frame();
    n = 0;
    while (!(rq.size() > 0 && rq[0].tag == epoch && beat == 6) && n < 3000) begin cycle(); n++; end
    chk("reached_mid_burst", n < 3000, 1'b1);
    start_frame();
    wait_frame(12000);

    // random restarts, then one clean frame
    p_pop = 60;
    for (int k = 0; k < 4; k++) begin
      start_frame();
      repeat ($urandom_range(30, 500)) cycle();
    end
    start_frame();
    wait_frame(12000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
